// File: rtl/score_to_ascii.sv
// score_to_ascii: sequential double-dabble binary-to-ASCII-decimal converter with start/busy/done handshake.
// Define SCORE_LEADING_BLANK_EN to render leading zero digits as spaces.
module score_to_ascii #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [7:0]           ascii [DIGITS]
);
    localparam int CW = BIN_WIDTH > 1 ? $clog2(BIN_WIDTH) : 1;
    localparam int BW = 4 * DIGITS;
`ifdef SCORE_LEADING_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

    state_t               state, state_nxt;
    logic [BIN_WIDTH-1:0] sreg;
    logic [BW-1:0]        bcd, bcd_adj;
    logic [CW-1:0]        cnt;
    logic                 ovf;
    logic                 seen;
    logic [3:0]           nib;
    logic [7:0]           fmt [DIGITS];

    function automatic logic [7:0] rst_char(int i);
        return (BLANK && i != DIGITS - 1) ? 8'h20 : 8'h30;
    endfunction

    always_ff @(posedge clk or negedge rst_l)
        if (!rst_l) state <= IDLE;
        else        state <= state_nxt;

    always_comb
        state_nxt = state == IDLE  ? (start ? SHIFT : IDLE) :
                    state == SHIFT ? (cnt == '0 ? FORMAT : SHIFT) : IDLE;

    always_comb begin
        busy = state != IDLE;
        for (int k = 0; k < DIGITS; k++)
            bcd_adj[4*k+:4] = bcd[4*k+:4] >= 4'd5 ? bcd[4*k+:4] + 4'd3 : bcd[4*k+:4];
    end

    // Scan from the most significant digit; the last digit always counts as seen so 0 prints '0'.
    always_comb begin
        seen = 1'b0;
        nib  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib    = bcd[4*(DIGITS-1-i)+:4];
            seen   = seen | (nib != 4'd0) | (i == DIGITS - 1);
            fmt[i] = ovf ? 8'h39 : (BLANK && !seen) ? 8'h20 : {4'h3, nib};
        end
    end

    always_ff @(posedge clk or negedge rst_l)
        if (!rst_l) begin
            sreg     <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < DIGITS; i++) ascii[i] <= rst_char(i);
        end else begin
            done <= state == FORMAT;
            if (state == IDLE && start) begin
                sreg <= bin;
                bcd  <= '0;
                ovf  <= 1'b0;
                cnt  <= CW'(BIN_WIDTH - 1);
            end
            if (state == SHIFT) begin
                {bcd, sreg} <= {bcd_adj, sreg} << 1;
                ovf         <= ovf | bcd_adj[BW-1];
                cnt         <= cnt - CW'(1);
            end
            if (state == FORMAT) begin
                ascii    <= fmt;
                overflow <= ovf;
            end
        end
endmodule

// File: tb/tb_score_to_ascii.sv
// tb_score_to_ascii: randomized self-checking bench for score_to_ascii at three parameter sets.
// Honours SCORE_LEADING_BLANK_EN in its reference model.
module tb_score_to_ascii;
    logic clk = 1'b0, rst_l = 1'b0;
    always #5 clk = ~clk;

    logic start0 = 1'b0; logic [15:0] bin0 = '0; logic busy0, done0, ovf0; logic [7:0] ascii0 [5];
    logic start1 = 1'b0; logic [9:0]  bin1 = '0; logic busy1, done1, ovf1; logic [7:0] ascii1 [3];
    logic start2 = 1'b0; logic        bin2 = '0; logic busy2, done2, ovf2; logic [7:0] ascii2 [1];

    int errors = 0, checks = 0;

    score_to_ascii #(.BIN_WIDTH(16), .DIGITS(5)) dut0 (.clk(clk), .rst_l(rst_l), .start(start0), .bin(bin0),
        .busy(busy0), .done(done0), .overflow(ovf0), .ascii(ascii0));
    score_to_ascii #(.BIN_WIDTH(10), .DIGITS(3)) dut1 (.clk(clk), .rst_l(rst_l), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .overflow(ovf1), .ascii(ascii1));
    score_to_ascii #(.BIN_WIDTH(1), .DIGITS(1)) dut2 (.clk(clk), .rst_l(rst_l), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .overflow(ovf2), .ascii(ascii2));

    function automatic int pw(int e);
        int p;
        p = 1;
        for (int k = 0; k < e; k++) p *= 10;
        return p;
    endfunction

    // Reference: the decimal rendering of v in d characters, index 0 leftmost.
    function automatic logic [7:0] exp_char(int v, int d, int i);
        if (v >= pw(d)) return 8'h39;
`ifdef SCORE_LEADING_BLANK_EN
        if (i < d - 1 && v < pw(d - 1 - i)) return 8'h20;
`endif
        return 8'h30 + 8'((v / pw(d - 1 - i)) % 10);
    endfunction

    function automatic logic [63:0] exp_s(int v, int d);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < d; i++) s = {s[55:0], exp_char(v, d, i)};
        return s;
    endfunction

    function automatic logic [63:0] got0();
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < 5; i++) s = {s[55:0], ascii0[i]};
        return s;
    endfunction

    function automatic logic [63:0] got1();
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < 3; i++) s = {s[55:0], ascii1[i]};
        return s;
    endfunction

    // Called at a negedge; returns at the negedge where done0 is seen (or the bound expires).
    task automatic conv0(input logic [15:0] v, input bit noise, output int lat, output bit bok);
        start0 = 1'b1; bin0 = v;
        @(negedge clk);
        start0 = 1'b0; lat = 0; bok = 1'b1;
        while (!done0 && lat < 40) begin
            bok &= busy0;
            if (noise) begin start0 = (lat == 2 || lat == 16); bin0 = 16'd7; end
            else bin0 = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        start0 = 1'b0;
        bok &= !busy0;
    endtask

    task automatic conv1(input logic [9:0] v, output int lat);
        start1 = 1'b1; bin1 = v;
        @(negedge clk);
        start1 = 1'b0; lat = 0;
        while (!done1 && lat < 40) begin
            bin1 = 10'($urandom);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (got0() !== exp_s(0, 5)) begin errors++; $display("FAIL reset_ascii0 got=%s want=%s", got0(), exp_s(0, 5)); end
        checks++; if (got1() !== exp_s(0, 3)) begin errors++; $display("FAIL reset_ascii1 got=%s want=%s", got1(), exp_s(0, 3)); end
        checks++; if (ascii2[0] !== exp_char(0, 1, 0)) begin errors++; $display("FAIL reset_ascii2 got=%h want=%h", ascii2[0], exp_char(0, 1, 0)); end
        checks++; if ({busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2} !== 9'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=0", {busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2});
        end
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_convert();
        int vals [$] = '{0, 1, 9, 10, 99, 100, 12345, 59999, 65535};
        int lat;
        bit bok;
        repeat (10) vals.push_back(int'($urandom_range(65535)));
        foreach (vals[k]) begin
            conv0(16'(vals[k]), 1'b0, lat, bok);
            checks++; if (lat !== 17) begin errors++; $display("FAIL convert_latency v=%0d got=%0d want=17", vals[k], lat); end
            checks++; if (!bok) begin errors++; $display("FAIL convert_busy v=%0d got=0 want=1", vals[k]); end
            checks++; if (got0() !== exp_s(vals[k], 5)) begin errors++; $display("FAIL convert_ascii v=%0d got=%s want=%s", vals[k], got0(), exp_s(vals[k], 5)); end
            checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL convert_ovf v=%0d got=%b want=0", vals[k], ovf0); end
            @(negedge clk);
            checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL convert_done_width v=%0d got=%b want=0", vals[k], done0); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bok;
        conv0(16'd12345, 1'b0, lat, bok);
        checks++; if (got0() !== exp_s(12345, 5)) begin errors++; $display("FAIL b2b_first got=%s want=%s", got0(), exp_s(12345, 5)); end
        conv0(16'd65535, 1'b0, lat, bok);
        checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_latency got=%0d want=17", lat); end
        checks++; if (!bok) begin errors++; $display("FAIL b2b_busy got=0 want=1"); end
        checks++; if (got0() !== exp_s(65535, 5)) begin errors++; $display("FAIL b2b_second got=%s want=%s", got0(), exp_s(65535, 5)); end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int lat;
        bit bok;
        conv0(16'd42, 1'b1, lat, bok);
        checks++; if (lat !== 17) begin errors++; $display("FAIL ignore_latency got=%0d want=17", lat); end
        checks++; if (!bok) begin errors++; $display("FAIL ignore_busy got=0 want=1"); end
        checks++; if (got0() !== exp_s(42, 5)) begin errors++; $display("FAIL ignore_ascii got=%s want=%s", got0(), exp_s(42, 5)); end
        @(negedge clk);
        checks++; if ({done0, busy0} !== 2'b00) begin errors++; $display("FAIL ignore_idle got=%b want=00", {done0, busy0}); end
    endtask

    task automatic test_small_overflow();
        int vals [$];
        int lat;
        repeat (4) vals.push_back(int'($urandom_range(1023)));
        vals.push_back(999);
        vals.push_back(1000);
        foreach (vals[k]) begin
            conv1(10'(vals[k]), lat);
            checks++; if (lat !== 11) begin errors++; $display("FAIL small_latency v=%0d got=%0d want=11", vals[k], lat); end
            checks++; if (got1() !== exp_s(vals[k], 3)) begin errors++; $display("FAIL small_ascii v=%0d got=%s want=%s", vals[k], got1(), exp_s(vals[k], 3)); end
            checks++; if (ovf1 !== (vals[k] > 999)) begin errors++; $display("FAIL small_ovf v=%0d got=%b want=%b", vals[k], ovf1, vals[k] > 999); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bok, seen;
        start0 = 1'b1; bin0 = 16'd9999;
        @(negedge clk);
        start0 = 1'b0;
        repeat (7) @(negedge clk);
        rst_l = 1'b0;
        #1;
        checks++; if (got0() !== exp_s(0, 5)) begin errors++; $display("FAIL midrst_ascii0 got=%s want=%s", got0(), exp_s(0, 5)); end
        checks++; if (got1() !== exp_s(0, 3)) begin errors++; $display("FAIL midrst_ascii1 got=%s want=%s", got1(), exp_s(0, 3)); end
        checks++; if ({busy0, done0, ovf0, ovf1} !== 4'b0) begin errors++; $display("FAIL midrst_flags got=%b want=0000", {busy0, done0, ovf0, ovf1}); end
        @(negedge clk);
        rst_l = 1'b1;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); seen |= done0 | busy0; end
        checks++; if (seen) begin errors++; $display("FAIL midrst_no_done got=1 want=0"); end
        conv0(16'd500, 1'b0, lat, bok);
        checks++; if (lat !== 17) begin errors++; $display("FAIL midrst_latency got=%0d want=17", lat); end
        checks++; if (got0() !== exp_s(500, 5)) begin errors++; $display("FAIL midrst_ascii got=%s want=%s", got0(), exp_s(500, 5)); end
        @(negedge clk);
    endtask

    task automatic test_one_bit();
        int lat;
        for (int v = 1; v >= 0; v--) begin
            start2 = 1'b1; bin2 = 1'(v);
            @(negedge clk);
            start2 = 1'b0; lat = 0;
            while (!done2 && lat < 10) begin @(negedge clk); lat++; end
            checks++; if (lat !== 2) begin errors++; $display("FAIL w1_latency v=%0d got=%0d want=2", v, lat); end
            checks++; if (ascii2[0] !== exp_char(v, 1, 0)) begin errors++; $display("FAIL w1_ascii v=%0d got=%h want=%h", v, ascii2[0], exp_char(v, 1, 0)); end
            checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL w1_ovf v=%0d got=%b want=0", v, ovf2); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_back_to_back();
        test_ignore_start();
        test_small_overflow();
        test_reset_mid();
        test_one_bit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/score_to_ascii.md
# score_to_ascii

Sequential binary-to-decimal converter that turns an unsigned binary value (score, lines cleared, level) into a fixed-width row of ASCII digit codes. It sits directly upstream of the 6x6 glyph lookup: each output byte drives that lookup's `character` input during text rendering. Conversion uses an iterative shift-and-add-3 (double-dabble) datapath, one bit per clock, under a start/busy/done handshake.

## Interface
- `BIN_WIDTH`, 16, width of the binary input; must be ≥ 1.
- `DIGITS`, 5, number of decimal digits produced; must be ≥ 1.

- `clk`  in  1  clock.
- `rst_l`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `bin`  in  BIN_WIDTH  unsigned value; captured on the edge that accepts `start`.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse; `ascii`/`overflow` are valid and updated.
- `overflow`  out  1  last conversion exceeded 10^DIGITS − 1.
- `ascii`  out  [7:0] × DIGITS (unpacked `[DIGITS]`)  result; index 0 is the most significant (leftmost) digit.

## Operation
- FSM states: IDLE, SHIFT, FORMAT.
- IDLE: `busy`=0. If `start`=1 at an edge: capture `bin` into shift register, clear BCD register (4×DIGITS bits) and sticky overflow, load bit counter with BIN_WIDTH−1, go to SHIFT.
- SHIFT: each cycle, every BCD nibble ≥ 5 gets +3 (4-bit add, no carry between nibbles), then {BCD, shift reg} shifts left by one. If the bit leaving the top BCD nibble is 1, set sticky overflow. When counter = 0, go to FORMAT; otherwise decrement.
- FORMAT: one cycle. Per digit: `ascii[i]` = 8'h30 + nibble (zero-extended to 8 bits). If sticky overflow set, every `ascii[i]` = 8'h39 ('9') instead (saturate). Register `ascii`, `overflow`, pulse `done`; return to IDLE.
- `ascii` and `overflow` change only on the FORMAT exit edge (or reset); they hold the previous result throughout a conversion.
- `start` while SHIFT or FORMAT: ignored, no queueing. `bin` changes after the capture edge have no effect.
- `start`=1 in the cycle `done` is high (state IDLE): accepted; back-to-back conversions allowed.
- Reset (any time, including mid-conversion): state IDLE, `busy`=0, `done`=0, `overflow`=0, every `ascii[i]`=8'h30 (see Configuration for blanked value); in-flight conversion discarded.

## Timing
- Edge E0 accepts `start`. Edges E1..E_BIN_WIDTH perform shifts. Edge E_(BIN_WIDTH+1) registers result.
- `busy` high for exactly BIN_WIDTH+1 cycles, from after E0 through the FORMAT cycle.
- `done` high for exactly one cycle, the cycle after E_(BIN_WIDTH+1), with `busy`=0.
- Start-to-done latency: BIN_WIDTH+1 cycles (17 at defaults).
- All outputs registered; no combinational path from `start`/`bin` to any output.

## Configuration
- `SCORE_LEADING_BLANK_EN` defined: in FORMAT, zero digits left of the first nonzero digit output 8'h20 (space, renders blank); `ascii[DIGITS-1]` is always a digit, so value 0 shows as a single '0'. Overflow saturation ('9's) is never blanked. Reset value: 8'h20 for indices 0..DIGITS−2, 8'h30 for index DIGITS−1.
- Not defined: all digits always shown, zero-padded; reset value all 8'h30.

## Test plan
- Defaults, `bin`=0 → after 17 cycles `done`=1, `ascii`="00000", `overflow`=0; with blank macro "    0".
- Defaults, `bin`=12345 then, on the `done` cycle, `start` with `bin`=65535 → "12345", then exactly 17 cycles later "65535"; `busy` never drops between conversions except the `done` cycle.
- DIGITS=3, BIN_WIDTH=10, `bin`=1000 → "999", `overflow`=1; next `bin`=999 → "999", `overflow`=0.
- Defaults, `start` with `bin`=42, pulse `start` with `bin`=7 at cycles 3 and 17 → ignored; result "00042" (blank macro: "   42") at latency 17 measured from the first start.
- `bin`=9999 start, assert `rst_l`=0 at cycle 8 for one cycle → all outputs at reset values immediately, no `done` pulse follows; new start with 500 → "00500" after 17 cycles.
- BIN_WIDTH=1, DIGITS=1, `bin`=1 → `done` 2 cycles after accept, `ascii[0]`=8'h31.
